serial_tx_frame: RTL and testbench
==================================

Name: serial_tx_frame

Overview:
Asynchronous-style serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line. Frame order is start bit, data bits LSB first, optional parity bit, then stop bit(s).
Acts as the transmit end of the team's serial link; the frame-capture receiver is the other end.
Built from flip-flop storage with the team-standard reset behaviour.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clk cycles each bit is held on tx_out (>=2)
PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
tx_data  input  DATA_W  word to transmit, sampled on handshake
tx_valid  input  1  word on tx_data is valid
tx_ready  output  1  block can accept a word; high only in IDLE
tx_out  output  1  serial line, idles high
busy  output  1  frame in progress (= ~tx_ready)
done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async, immediate, also mid-frame): state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0. Bit counter, cycle counter and shift register are cleared. A partially sent frame is abandoned with no done pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1.
  - tx_valid&&tx_ready on an edge: latch tx_data into the shift register, compute the parity bit, go to START.
  - tx_out goes 0 on the next cycle, i.e. 1 cycle of latency from handshake to the start-bit edge.
- Each bit is held exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1; the state or bit advances when it reaches CLKS_PER_BIT-1.
- START: tx_out=0, then DATA.
- DATA: tx_out = shift_reg[0], shifted right per bit. After DATA_W bits go to PARITY if PARITY_EN, else STOP.
- PARITY: tx_out = XOR of latched data, XOR PARITY_ODD.
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 in the final cycle, then IDLE.
- Frame length: (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back: tx_ready rises the cycle after done. With tx_valid held high, the next handshake occurs in that cycle. Exactly one extra high cycle separates the end of the stop bit(s) from the next start bit.
- tx_valid while busy is ignored (no buffering, no error). tx_data changes after the handshake do not affect the frame in flight.
- tx_valid asserted in the same cycle reset deasserts: accepted on the first rising edge with rst low.
- Outputs are registered except tx_ready and busy, which are decoded directly from the state register (glitch-free, no input dependence).

Test Plan:
- Reset: assert rst mid-simulation with no clk edges -> tx_out=1, tx_ready=1, busy=0, done=0 immediately.
- CLKS_PER_BIT=4, even parity, 1 stop, send 0xA5.
  - tx_out per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - 44 cycles from the start edge; done pulses once in cycle 44.
- PARITY_ODD=1, send 0x01 -> parity slot = 0. Send 0x03 -> parity slot = 1.
- PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=4, send 0xFF -> start slot, 8 high slots, 2 stop slots; 44 cycles total; no parity slot.
- Back-to-back: hold tx_valid=1 with 0x55 then 0xAA -> exactly 1 high cycle between the final stop cycle and the second start bit. The second frame bits match 0xAA. tx_data changed mid-frame does not alter the first frame.
- Reset at cycle 20 of a 0xA5 frame -> tx_out=1 at once, no done pulse. Release and send 0x3C -> complete correct frame.

Source files
------------

// File: rtl/serial_tx_frame.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional parity, stop bit(s).
// A word is taken over a valid/ready handshake in IDLE only, and each bit is held CLKS_PER_BIT clocks.
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_PRE   = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     cyc_reg;
    logic [BW-1:0]     bit_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_reg;
    logic              tx_out_reg;
    logic              done_reg;

    // Parity is folded from the incoming word so it is ready at the handshake.
    logic [DATA_W:0]   par_chain;
    assign par_chain[0] = (PARITY_ODD != 0);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ tx_data[gi];
        end
    endgenerate

    logic [DATA_W-1:0] shift_shr;
    assign shift_shr = shift_reg >> 1;

    logic cyc_last;
    assign cyc_last = (cyc_reg == CYC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cyc_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_out_reg <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_out_reg <= 1'b1;
                    cyc_reg    <= '0;
                    bit_reg    <= '0;
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_reg <= par_chain[DATA_W];
                        tx_out_reg <= 1'b0;
                        state_reg  <= START;
                    end
                end

                START: begin
                    if (cyc_last) begin
                        cyc_reg    <= '0;
                        tx_out_reg <= shift_reg[0];
                        state_reg  <= DATA;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end

                DATA: begin
                    if (cyc_last) begin
                        cyc_reg <= '0;
                        if (bit_reg == BIT_LAST) begin
                            bit_reg <= '0;
                            if (PARITY_EN != 0) begin
                                tx_out_reg <= parity_reg;
                                state_reg  <= PARITY;
                            end else begin
                                tx_out_reg <= 1'b1;
                                state_reg  <= STOP;
                            end
                        end else begin
                            bit_reg    <= bit_reg + BW'(1);
                            shift_reg  <= shift_shr;
                            tx_out_reg <= shift_shr[0];
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end

                PARITY: begin
                    if (cyc_last) begin
                        cyc_reg    <= '0;
                        tx_out_reg <= 1'b1;
                        state_reg  <= STOP;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end

                STOP: begin
                    tx_out_reg <= 1'b1;
                    // done is registered, so it is raised one cycle ahead to land on the final cycle.
                    if (cyc_reg == CYC_PRE && bit_reg == STOP_LAST) begin
                        done_reg <= 1'b1;
                    end
                    if (cyc_last) begin
                        cyc_reg <= '0;
                        if (bit_reg == STOP_LAST) begin
                            bit_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            bit_reg <= bit_reg + BW'(1);
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    tx_out_reg <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign tx_out   = tx_out_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: three instances (even parity, odd parity, no parity with two stops),
// all at 4 clocks per bit, driven from a table of frames plus back-to-back and mid-frame reset sequences.
module tb_serial_tx_frame;

    logic       clk;
    logic       rst;
    logic [2:0] tx_valid;
    logic [7:0] tx_data [3];
    logic [2:0] tx_ready;
    logic [2:0] tx_out;
    logic [2:0] busy;
    logic [2:0] done;

    int checks = 0;
    int errors = 0;

    logic tr_out  [0:255];
    logic tr_done [0:255];
    logic tr_rdy  [0:255];

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_nopar (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slots: bit i is the expected line level during slot i (slot 0 = start bit)
    typedef struct {
        int         unit;
        logic [7:0] data;
        logic [10:0] slots;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_frame(input int u, input logic [7:0] d);
        int w;
        w = 0;
        while (!tx_ready[u] && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!tx_ready[u]) chk("ready_wait", 0, 1);
        tx_data[u]  = d;
        tx_valid[u] = 1'b1;
        @(posedge clk); #1;
    endtask

    // Records n cycles starting at trace index 1; drops tx_valid after sampling cycle drop_at.
    task automatic capture(input int u, input int n, input int drop_at);
        for (int c = 1; c <= n; c++) begin
            tr_out[c]  = tx_out[u];
            tr_done[c] = done[u];
            tr_rdy[c]  = tx_ready[u];
            if (c == drop_at) tx_valid[u] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_frame(input string name, input int off, input logic [10:0] exp);
        logic [10:0] obs;
        int hold_bad, done_cnt, done_pos, rdy_cnt;
        obs = '0;
        hold_bad = 0; done_cnt = 0; done_pos = -1; rdy_cnt = 0;
        for (int s = 0; s < 11; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0) obs[s] = tr_out[off + s*4];
                else if (tr_out[off + s*4 + k] != obs[s]) hold_bad++;
            end
        end
        for (int c = off; c < off + 44; c++) begin
            if (tr_done[c]) begin
                done_cnt++;
                done_pos = c - off + 1;
            end
            if (tr_rdy[c]) rdy_cnt++;
        end
        $display("frame %s: slots=%b expected=%b done_at=%0d", name, obs, exp, done_pos);
        chk({name, "_slots"}, int'(obs), int'(exp));
        chk({name, "_hold"}, hold_bad, 0);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_done_pos"}, done_pos, 44);
        chk({name, "_ready_low"}, rdy_cnt, 0);
        chk({name, "_idle_after"}, int'({tr_out[off+44], tr_rdy[off+44]}), 3);
    endtask

    initial begin
        int dcnt;

        vecs[0]  = '{0, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1]  = '{0, 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}};
        vecs[2]  = '{0, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[3]  = '{0, 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
        vecs[4]  = '{0, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[5]  = '{0, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
        vecs[6]  = '{1, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0}};
        vecs[7]  = '{1, 8'h03, {1'b1, 1'b1, 8'h03, 1'b0}};
        vecs[8]  = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[9]  = '{1, 8'h7F, {1'b1, 1'b0, 8'h7F, 1'b0}};
        vecs[10] = '{2, 8'hFF, {2'b11, 8'hFF, 1'b0}};
        vecs[11] = '{2, 8'h5A, {2'b11, 8'h5A, 1'b0}};

        tx_valid = '0;
        for (int u = 0; u < 3; u++) tx_data[u] = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++)
            chk($sformatf("reset_u%0d", u), int'({tx_out[u], tx_ready[u], busy[u], done[u]}), 4'b1100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            start_frame(vecs[i].unit, vecs[i].data);
            capture(vecs[i].unit, 45, 1);
            check_frame($sformatf("u%0d_%h", vecs[i].unit, vecs[i].data), 1, vecs[i].slots);
        end

        // Back-to-back with tx_valid held: data switched to 0xAA right after the first handshake.
        start_frame(0, 8'h55);
        tx_data[0] = 8'hAA;
        capture(0, 90, 46);
        check_frame("b2b_first_55", 1, {1'b1, 1'b0, 8'h55, 1'b0});
        check_frame("b2b_second_AA", 46, {1'b1, 1'b0, 8'hAA, 1'b0});

        // Reset in cycle 20 of a 0xA5 frame, with no clock edge before the check.
        start_frame(0, 8'hA5);
        capture(0, 19, 1);
        chk("pre_reset_line", int'(tx_out[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_frame_reset", int'({tx_out[0], tx_ready[0], busy[0], done[0]}), 4'b1100);
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done[0]) dcnt++;
        end
        chk("reset_no_done", dcnt, 0);
        // tx_valid rises together with reset release and is taken on the first edge.
        rst = 1'b0;
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        @(posedge clk); #1;
        capture(0, 45, 1);
        check_frame("after_reset_3C", 1, {1'b1, 1'b0, 8'h3C, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
